// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine with HI/LO ownership.
// One shift-add or restoring shift-subtract step per cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             startE,
  input  logic [2:0]       opE,
  input  logic [WIDTH-1:0] srcAE,
  input  logic [WIDTH-1:0] srcBE,
  input  logic             flushE,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] ql_q;
  logic [WIDTH-1:0] m_q;
  logic             div_q;
  logic             neg_q;
  logic             nega_q;
  logic             divz_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;

  logic             sgn;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             accept;
  logic             wr_hi;
  logic             wr_lo;

  // Decode of the instruction sitting in EX while the unit is idle
  always_comb begin
    sgn    = ~opE[0];
    a_neg  = sgn & srcAE[WIDTH-1];
    b_neg  = sgn & srcBE[WIDTH-1];
    mag_a  = a_neg ? -srcAE : srcAE;
    mag_b  = b_neg ? -srcBE : srcBE;
    accept = 1'b0;
    wr_hi  = 1'b0;
    wr_lo  = 1'b0;
    if (state_q == IDLE && startE && !flushE) begin
      unique case (1'b1)
        !opE[2]:         accept = 1'b1;
        opE == 3'd4:     wr_hi  = 1'b1;
        opE == 3'd5:     wr_lo  = 1'b1;
        default: ;
      endcase
    end
  end

  assign busy = accept | (state_q == RUN);

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     rsh;
  logic [WIDTH:0]     sub;
  logic               ge;
  logic [WIDTH-1:0]   acc_d;
  logic [WIDTH-1:0]   ql_d;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_c;
  logic [WIDTH-1:0]   q_c;
  logic [WIDTH-1:0]   r_c;
  logic [WIDTH-1:0]   hi_res;
  logic [WIDTH-1:0]   lo_res;
  logic               unused_bits;

  // One iteration step plus sign-corrected final results
  always_comb begin
    sum = {1'b0, acc_q} + {1'b0, (ql_q[0] ? m_q : '0)};
    rsh = {acc_q, ql_q[WIDTH-1]};
    sub = rsh - {1'b0, m_q};
    ge  = (rsh >= {1'b0, m_q});
    if (div_q) begin
      acc_d = ge ? sub[WIDTH-1:0] : rsh[WIDTH-1:0];
      ql_d  = {ql_q[WIDTH-2:0], ge};
    end else begin
      acc_d = sum[WIDTH:1];
      ql_d  = {sum[0], ql_q[WIDTH-1:1]};
    end
    prod   = {acc_d, ql_d};
    prod_c = neg_q ? -prod : prod;
    q_c    = neg_q ? -ql_d : ql_d;
    r_c    = nega_q ? -acc_d : acc_d;
    if (div_q) begin
      hi_res = r_c;
      lo_res = divz_q ? '1 : q_c;
    end else begin
      hi_res = prod_c[2*WIDTH-1:WIDTH];
      lo_res = prod_c[WIDTH-1:0];
    end
  end

  assign unused_bits = ^{sub[WIDTH], rsh[WIDTH]};

  // Control FSM, iteration registers and HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      ql_q    <= '0;
      m_q     <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      nega_q  <= 1'b0;
      divz_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= RUN;
            cnt_q   <= CW'(WIDTH - 1);
            acc_q   <= '0;
            ql_q    <= mag_a;
            m_q     <= mag_b;
            div_q   <= opE[1];
            neg_q   <= a_neg ^ b_neg;
            nega_q  <= a_neg;
            divz_q  <= (srcBE == '0);
          end else begin
            if (wr_hi) hi_q <= srcAE;
            if (wr_lo) lo_q <= srcAE;
          end
        end
        RUN: begin
          if (flushE) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            acc_q <= acc_d;
            ql_q  <= ql_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
              state_q <= DONE;
              hi_q    <= hi_res;
              lo_q    <= lo_res;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit.
// Expected HI/LO tracked in m_hi/m_lo.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        startE;
  logic [2:0]  opE;
  logic [31:0] srcAE;
  logic [31:0] srcBE;
  logic        flushE;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .startE (startE),
    .opE    (opE),
    .srcAE  (srcAE),
    .srcBE  (srcBE),
    .flushE (flushE),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo),
    .done   (done)
  );

  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi,
                        input logic [31:0] elo, input string name);
    int cnt;
    int early;
    int hold_bad;
    cnt = 0;
    early = 0;
    hold_bad = 0;
    @(negedge clk);
    opE = op; srcAE = a; srcBE = b; startE = 1'b1;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (!busy) break;
      cnt++;
      if (done) early++;
      if (k == 5 && (hi !== m_hi || lo !== m_lo)) hold_bad++;
      @(negedge clk);
    end
    nvec++;
    if (cnt !== 33) begin
      nerr++;
      $display("FAIL %s busy_cycles got=%0d exp=33", name, cnt);
    end
    nvec++;
    if (early !== 0 || hold_bad !== 0) begin
      nerr++;
      $display("FAIL %s run_phase early_done=%0d hold_bad=%0d exp=0/0",
               name, early, hold_bad);
    end
    nvec++;
    if (done !== 1'b1) begin
      nerr++;
      $display("FAIL %s done_pulse got=%b exp=1", name, done);
    end
    nvec++;
    if (hi !== ehi || lo !== elo) begin
      nerr++;
      $display("FAIL %s result got=%h_%h exp=%h_%h", name, hi, lo, ehi, elo);
    end
    m_hi = ehi;
    m_lo = elo;
    @(posedge clk);
    #1 startE = 1'b0;
    @(negedge clk);
    nvec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL %s after_done got done=%b busy=%b exp=0/0",
               name, done, busy);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; startE = 1'b0; opE = 3'd0;
    srcAE = '0; srcBE = '0; flushE = 1'b0;
    m_hi = '0; m_lo = '0;
    #12;
    nvec++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      nerr++;
      $display("FAIL reset got hi=%h lo=%h busy=%b done=%b exp=0",
               hi, lo, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_multu;
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
  endtask

  task automatic test_mult_div;
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7,
           32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg3x7");
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7by2");
    run_op(3'd3, 32'd7, 32'd3, 32'd1, 32'd2, "divu_7by3");
    run_op(3'd0, 32'h8000_0000, 32'h8000_0000,
           32'h4000_0000, 32'h0000_0000, "mult_min_sq");
    run_op(3'd0, 32'h8000_0000, 32'd1,
           32'hFFFF_FFFF, 32'h8000_0000, "mult_min_x1");
  endtask

  task automatic test_div_edge;
    run_op(3'd3, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, "divu_by0");
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h0, 32'h8000_0000, "div_min_by_m1");
    run_op(3'd2, 32'hFFFF_FFF9, 32'd0,
           32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_neg_by0");
  endtask

  task automatic test_flush;
    int dcnt;
    dcnt = 0;
    @(negedge clk);
    opE = 3'd3; srcAE = 32'd1000; srcBE = 32'd7; startE = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    nvec++;
    if (busy !== 1'b1) begin
      nerr++;
      $display("FAIL flush_pre busy got=%b exp=1", busy);
    end
    flushE = 1'b1;
    @(negedge clk);
    #1;
    nvec++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      nerr++;
      $display("FAIL flush_post got busy=%b done=%b hi=%h lo=%h exp 0/0/%h/%h",
               busy, done, hi, lo, m_hi, m_lo);
    end
    startE = 1'b0; flushE = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    nvec++;
    if (dcnt !== 0 || hi !== m_hi || lo !== m_lo) begin
      nerr++;
      $display("FAIL flush_quiet got activity=%0d hi=%h lo=%h exp 0/%h/%h",
               dcnt, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_mtxx;
    @(negedge clk);
    opE = 3'd5; srcAE = 32'h0000_1234; startE = 1'b1;
    #1;
    nvec++;
    if (busy !== 1'b0) begin
      nerr++;
      $display("FAIL mtlo_busy got=%b exp=0", busy);
    end
    @(negedge clk);
    m_lo = 32'h0000_1234;
    nvec++;
    if (lo !== m_lo || hi !== m_hi || busy !== 1'b0 || done !== 1'b0) begin
      nerr++;
      $display("FAIL mtlo got hi=%h lo=%h busy=%b done=%b exp %h/%h/0/0",
               hi, lo, busy, done, m_hi, m_lo);
    end
    opE = 3'd4; srcAE = 32'h0000_ABCD;
    @(negedge clk);
    m_hi = 32'h0000_ABCD;
    nvec++;
    if (hi !== m_hi || lo !== m_lo) begin
      nerr++;
      $display("FAIL mthi got hi=%h lo=%h exp %h/%h", hi, lo, m_hi, m_lo);
    end
    opE = 3'd6; srcAE = 32'h5555_5555; srcBE = 32'h3;
    #1;
    nvec++;
    if (busy !== 1'b0) begin
      nerr++;
      $display("FAIL op6_busy got=%b exp=0", busy);
    end
    @(negedge clk);
    opE = 3'd7;
    @(negedge clk);
    nvec++;
    if (hi !== m_hi || lo !== m_lo || done !== 1'b0) begin
      nerr++;
      $display("FAIL op67_noop got hi=%h lo=%h done=%b exp %h/%h/0",
               hi, lo, done, m_hi, m_lo);
    end
    opE = 3'd4; srcAE = 32'h9999_9999; flushE = 1'b1;
    @(negedge clk);
    nvec++;
    if (hi !== m_hi) begin
      nerr++;
      $display("FAIL mthi_flushed got hi=%h exp %h", hi, m_hi);
    end
    startE = 1'b0; flushE = 1'b0;
  endtask

  task automatic test_back_to_back;
    int bc;
    int dc;
    bc = 0;
    dc = 0;
    @(negedge clk);
    opE = 3'd0; srcAE = 32'd5; srcBE = 32'hFFFF_FFFA; startE = 1'b1;
    for (int k = 0; k < 120; k++) begin
      #1;
      if (busy) bc++;
      if (done) dc++;
      if (dc == 2 && startE) startE = 1'b0;
      @(negedge clk);
    end
    startE = 1'b0;
    m_hi = 32'hFFFF_FFFF;
    m_lo = 32'hFFFF_FFE2;
    nvec++;
    if (bc !== 66 || dc !== 2) begin
      nerr++;
      $display("FAIL b2b_count got busy=%0d done=%0d exp 66/2", bc, dc);
    end
    nvec++;
    if (hi !== m_hi || lo !== m_lo) begin
      nerr++;
      $display("FAIL b2b_result got %h_%h exp %h_%h", hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_reset_mid_run;
    @(negedge clk);
    opE = 3'd1; srcAE = 32'hFFFF_FFFF; srcBE = 32'd2; startE = 1'b1;
    repeat (8) @(negedge clk);
    rst_n = 1'b0; startE = 1'b0;
    #1;
    m_hi = '0;
    m_lo = '0;
    nvec++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      nerr++;
      $display("FAIL reset_mid got hi=%h lo=%h busy=%b done=%b exp 0",
               hi, lo, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd1, 32'd6, 32'd7, 32'd0, 32'd42, "multu_6x7");
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult_div();
    test_div_edge();
    test_flush();
    test_mtxx();
    test_back_to_back();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
